// File: rtl/mod_clkgen_multi.sv
// Multi-channel counter-derived modulated clock generator.
// Per-channel phase/duty/polarity, glitch-free reconfig, run/stop and burst.
module mod_clkgen_multi #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 5,
  parameter int BURST_W = 16
) (
  input  logic                      CLK_IN,
  input  logic                      RST_B,
  input  logic [CNT_W-1:0]          PERIOD_SEL,
  input  logic [NUM_CH*CNT_W-1:0]   PHASE_SEL,
  input  logic [NUM_CH*CNT_W-1:0]   DUTY_SEL,
  input  logic [NUM_CH-1:0]         INVERT,
  input  logic                      CFG_LOAD,
  input  logic                      RUN,
  input  logic [BURST_W-1:0]        BURST_LEN,
  output logic [NUM_CH-1:0]         CLK_OUT_MOD,
  output logic                      PERIOD_STROBE,
  output logic                      CFG_ACK,
  output logic                      BUSY,
  output logic                      DONE
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    STOPPING
  } state_t;

  localparam logic [CNT_W:0]   W_ONE   = 1;
  localparam logic [CNT_W:0]   W_TWO   = 2;
  localparam logic [CNT_W-1:0] C_ONE   = 1;
  localparam logic [BURST_W:0] B_ONE_W = 1;
  localparam logic [BURST_W-1:0] B_ONE = 1;

  state_t state_q, state_d;

  logic [CNT_W-1:0]        cnt_q;
  logic [BURST_W-1:0]      burst_cnt_q;
  logic [BURST_W-1:0]      burst_len_q;

  logic [CNT_W:0]          act_p, pnd_p;
  logic [NUM_CH*CNT_W-1:0] act_ph, pnd_ph;
  logic [NUM_CH*CNT_W-1:0] act_du, pnd_du;
  logic [NUM_CH-1:0]       act_inv, pnd_inv;
  logic                    pnd_q;

  logic [NUM_CH-1:0]       out_q;
  logic                    ack_q;
  logic                    done_q;

  logic                    busy;
  logic                    wrap;
  logic                    burst_end;
  logic                    apply;
  logic [CNT_W:0]          sel_p;
  logic [CNT_W:0]          last_w;
  logic [NUM_CH-1:0]       raw;

  // Unsigned CNT_W+1 arithmetic keeps c+p-ph from overflowing.
  function automatic logic wave_bit(
    input logic [CNT_W:0] c,
    input logic [CNT_W:0] p,
    input logic [CNT_W:0] ph_in,
    input logic [CNT_W:0] du
  );
    logic [CNT_W:0] ph;
    logic [CNT_W:0] pos;
    ph  = (ph_in >= p) ? p - W_ONE : ph_in;
    pos = (c >= ph) ? c - ph : c + p - ph;
    return (du >= p) ? 1'b1 : (pos < du);
  endfunction

  assign busy      = (state_q != IDLE);
  assign last_w    = act_p - W_ONE;
  assign wrap      = busy && ({1'b0, cnt_q} == last_w);
  assign burst_end = (burst_len_q != '0) &&
                     (({1'b0, burst_cnt_q} + B_ONE_W) == {1'b0, burst_len_q});
  assign apply     = pnd_q && (!busy || wrap);
  assign sel_p     = (PERIOD_SEL == '0) ? W_TWO
                                        : {1'b0, PERIOD_SEL} + W_ONE;

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = wave_bit({1'b0, cnt_q}, act_p,
                        {1'b0, act_ph[i*CNT_W +: CNT_W]},
                        {1'b0, act_du[i*CNT_W +: CNT_W]});
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (RUN) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (wrap) begin
          if (!RUN || burst_end) state_d = IDLE;
        end else if (!RUN) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (wrap)     state_d = IDLE;
        else if (RUN) state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_B) begin
    if (!RST_B) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      burst_cnt_q <= '0;
      burst_len_q <= '0;
      act_p       <= W_TWO;
      act_ph      <= '0;
      act_du      <= '0;
      act_inv     <= '0;
      pnd_p       <= W_TWO;
      pnd_ph      <= '0;
      pnd_du      <= '0;
      pnd_inv     <= '0;
      pnd_q       <= 1'b0;
      out_q       <= '0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= busy && (state_d == IDLE);
      ack_q   <= apply;

      if (!busy || wrap) cnt_q <= '0;
      else               cnt_q <= cnt_q + C_ONE;

      if (!busy && RUN) begin
        burst_cnt_q <= '0;
        burst_len_q <= BURST_LEN;
      end else if (wrap && (burst_cnt_q != '1)) begin
        burst_cnt_q <= burst_cnt_q + B_ONE;
      end

      if (apply) begin
        act_p   <= pnd_p;
        act_ph  <= pnd_ph;
        act_du  <= pnd_du;
        act_inv <= pnd_inv;
      end

      // A load coinciding with an apply is kept for the next boundary.
      if (CFG_LOAD) begin
        pnd_p   <= sel_p;
        pnd_ph  <= PHASE_SEL;
        pnd_du  <= DUTY_SEL;
        pnd_inv <= INVERT;
        pnd_q   <= 1'b1;
      end else if (apply) begin
        pnd_q   <= 1'b0;
      end

      out_q <= busy ? (raw ^ act_inv) : act_inv;
    end
  end

  assign CLK_OUT_MOD   = out_q;
  assign PERIOD_STROBE = busy && (cnt_q == '0);
  assign CFG_ACK       = ack_q;
  assign BUSY          = busy;
  assign DONE          = done_q;

endmodule
